transfer_scheduler: RTL

Arbiter and sequencer placed in front of the transfer center. It shares the center's single serial input between two local scanners. Round-robin arbitration picks a requesting scanner and latches its 8-bit buffer. The block then waits for the center to signal ready and shifts the byte out MSB-first as a framed serial burst. It reports which scanner owns the link, and flags completion or timeout.

---
 rtl/transfer_scheduler_pkg.sv | 37 +++
 rtl/transfer_piso.sv | 45 ++++
 rtl/transfer_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/transfer_scheduler_pkg.sv
// Shared definitions for the transfer scheduler: state encoding, link-owner codes,
// default frame width (matched to the transfer center) and the round-robin pick helper.
package transfer_scheduler_pkg;

  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned TMO_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ACTIVE_NONE = 2'b00;
  localparam logic [1:0] ACTIVE_S0   = 2'b01;
  localparam logic [1:0] ACTIVE_S1   = 2'b10;

  typedef struct packed {
    logic valid;
    logic sel;
  } arb_pick_t;

  function automatic logic [1:0] active_code(input logic sel);
    return sel ? ACTIVE_S1 : ACTIVE_S0;
  endfunction

  // Ties go to the scanner that was not served last.
  function automatic arb_pick_t rr_pick(input logic [1:0] req, input logic last);
    arb_pick_t p;
    p.valid = |req;
    p.sel   = (req == 2'b11) ? ~last : req[1];
    return p;
  endfunction

endpackage

// File: rtl/transfer_piso.sv
// Parallel-in/serial-out frame register with bit counter; MSB leaves first and
// last flags the final bit of the frame.
module transfer_piso
  import transfer_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              shift,
  input  logic              clr,
  output logic              msb,
  output logic              last
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        sreg_q <= data;
      end else if (shift) begin
        sreg_q <= sreg_q << 1;
      end
      if (clr || load) begin
        cnt_q <= '0;
      end else if (shift) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign msb  = sreg_q[DATA_W-1];
  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/transfer_scheduler.sv
// Round-robin arbiter and frame sequencer sharing the transfer center's serial
// input between two scanners, with ready wait, timeout abort and completion pulse.
module transfer_scheduler
  import transfer_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        scanReq,
  input  logic [DATA_W-1:0] scanData0,
  input  logic [DATA_W-1:0] scanData1,
  input  logic              centerReady,
  output logic [1:0]        scanGrant,
  output logic [1:0]        activeScanner,
  output logic              serialOut,
  output logic              serialValid,
  output logic              transferDone,
  output logic              timeoutErr
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;

  logic              piso_load, piso_shift, piso_clr;
  logic              piso_msb, piso_last;
  logic [DATA_W-1:0] load_data;
  arb_pick_t         pick;

  assign pick      = rr_pick(scanReq, last_q);
  assign load_data = pick.sel ? scanData1 : scanData0;

  transfer_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .data  (load_data),
    .shift (piso_shift),
    .clr   (piso_clr),
    .msb   (piso_msb),
    .last  (piso_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer resets to "scanner 1 served last" so scanner 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= ACTIVE_NONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    last_d     = last_q;
    sel_d      = sel_q;
    tcnt_d     = tcnt_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          sel_d     = pick.sel;
          grant_d   = active_code(pick.sel);
          tcnt_d    = '0;
          piso_load = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (centerReady) begin
          piso_clr = 1'b1;
          last_d   = sel_q;
          state_d  = ST_SHIFT;
        end else if (tcnt_q == TMO_LAST) begin
          tcnt_d  = tcnt_q + TMO_W'(1);
          err_d   = 1'b1;
          last_d  = sel_q;
          grant_d = ACTIVE_NONE;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        if (piso_last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = ACTIVE_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = ACTIVE_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign scanGrant     = grant_q;
  assign activeScanner = grant_q;
  assign transferDone  = done_q;
  assign timeoutErr    = err_q;
  assign serialValid   = (state_q == ST_SHIFT);
  assign serialOut     = (state_q == ST_SHIFT) && piso_msb;

endmodule
